mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Multi-cycle sequencer between the MIPS pipeline MEM stage and a variable-latency data memory.
- Accepts one load/store request at a time, checks alignment and generates byte enables.
- Holds the memory request until it is acknowledged or times out.
- On load completion, drives load_signal to the load unit and pulses write-back valid. Stalls the pipeline while busy.

Parameters:
- TIMEOUT, 16: maximum cycles in REQ without mem_ack before a timeout error (range 2..255).
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline presents a memory operation
- req_ready  out  1  controller can accept; equals (state==IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- mem_en  out  1  memory request strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  store data replicated into lanes
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completion, single-cycle
- load_signal  out  2  size code to load unit, valid when wb_valid=1
- wb_valid  out  1  load data ready for write-back, 1-cycle pulse
- st_done  out  1  store complete, 1-cycle pulse
- stall  out  1  pipeline hold; equals (state!=IDLE)
- align_err  out  1  misaligned access, 1-cycle pulse
- timeout_err  out  1  no ack within TIMEOUT, 1-cycle pulse

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, counter=0, all registered outputs 0. req_ready=1 and stall=0 during and after reset.
- States: IDLE, REQ, DONE, ERR.
- IDLE: on req_valid, latch we/size/addr/wdata and check alignment.
  - Misaligned: word with addr[1:0]!=0, or half with addr[0]!=0. Go to ERR; no mem_en is issued.
  - Aligned: go to REQ.
- REQ: mem_en=1, with mem_we/mem_addr/mem_wdata/mem_be constant from latched values. Counter increments each cycle.
  - mem_ack=1: go to DONE, clear counter.
  - No ack and counter==TIMEOUT-1: go to ERR with timeout flag.
  - Ack on the same cycle as the timeout condition: ack wins.
- DONE: exactly one cycle, then IDLE.
  - Load: wb_valid=1, load_signal=latched size.
  - Store: st_done=1.
- ERR: exactly one cycle. align_err or timeout_err=1 matching the cause, then IDLE.
- load_signal holds its last value outside DONE (0 after reset).
- Byte enables (little-endian):
  - Word: 1111.
  - Half: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - Byte (10, 11): 0001 << addr[1:0].
- Store data lanes:
  - Word: as-is.
  - Half: {wdata[15:0],wdata[15:0]}.
  - Byte: wdata[7:0] replicated ×4.
- For loads, mem_be is set per size; mem_we=0 and mem_wdata is don't-care but driven 0.
- Latency: accept at edge N, mem_en high from cycle N+1. An ack sampled at edge N+1+k gives DONE in the following cycle.
  - Minimum acceptance-to-wb_valid: 2 cycles.
  - Minimum back-to-back request spacing: 3 cycles.
- Requests arriving while busy are ignored (req_ready=0); the pipeline must hold them.
- mem_ack outside REQ is ignored.
- Reset mid-REQ aborts the access immediately: mem_en drops with reset, and no done or error pulse follows.

Test Plan:
- Load word: addr=0x00000010, size=00, ack 3 cycles after mem_en rises -> mem_addr=0x10, mem_be=1111, mem_en high 3 cycles, then wb_valid=1 with load_signal=00 for one cycle, stall low the cycle after.
- Store half: addr=0x22, wdata=0x0000ABCD, size=01, immediate ack -> mem_we=1, mem_addr=0x20, mem_be=1100, mem_wdata=0xABCDABCD, st_done pulse, wb_valid stays 0.
- Byte lanes: loads size=10 at addr 0x40..0x43 -> mem_be=0001, 0010, 0100, 1000; size=11 at 0x41 -> load_signal=11 on wb_valid.
- Misalignment: word at 0x06 and half at 0x03 -> align_err pulse one cycle after acceptance, mem_en never asserted, back in IDLE next cycle.
- Timeout: TIMEOUT=16, never ack -> mem_en high exactly 16 cycles, timeout_err pulse, no wb_valid. Repeat with ack on the 16th cycle -> wb_valid, no timeout_err.
- Reset abort: deassert rst_n during the 2nd REQ cycle -> mem_en=0 immediately, req_ready=1, no pulses. A new request after release completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Bundle of pipeline-side request, memory-side and completion signals for mem_access_ctrl.
// slave is the controller's view, master is the pipeline/memory environment's view.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [1:0]  load_signal;
  logic        wb_valid;
  logic        st_done;
  logic        stall;
  logic        align_err;
  logic        timeout_err;

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, mem_ack,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_be,
           load_signal, wb_valid, st_done, stall, align_err, timeout_err
  );

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, mem_ack,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_be,
           load_signal, wb_valid, st_done, stall, align_err, timeout_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle MEM-stage sequencer: one load/store at a time, alignment check, byte-lane
// generation, request hold until ack or timeout, then a one-cycle completion/error pulse.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [1:0]       size_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [3:0]       mem_be_q;
  logic [1:0]       load_signal_q;
  logic             wb_valid_q;
  logic             st_done_q;
  logic             align_err_q;
  logic             timeout_err_q;
  logic             misaligned_d;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b1111;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b0001 << off;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = wdata;
      2'b01:   d = {2{wdata[15:0]}};
      default: d = {4{wdata[7:0]}};
    endcase
    return d;
  endfunction

  always_comb begin
    misaligned_d = 1'b0;
    if (bus.req_size == 2'b00)
      misaligned_d = (bus.req_addr[1:0] != 2'b00);
    else if (bus.req_size == 2'b01)
      misaligned_d = bus.req_addr[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      load_signal_q <= 2'b00;
      wb_valid_q    <= 1'b0;
      st_done_q     <= 1'b0;
      align_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wb_valid_q    <= 1'b0;
      st_done_q     <= 1'b0;
      align_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q   <= bus.req_we;
            size_q <= bus.req_size;
            if (misaligned_d) begin
              state_q     <= ERR;
              align_err_q <= 1'b1;
            end else begin
              state_q     <= REQ;
              cnt_q       <= '0;
              mem_en_q    <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_be_q    <= byte_en(bus.req_size, bus.req_addr[1:0]);
              mem_wdata_q <= bus.req_we ? lane_data(bus.req_size, bus.req_wdata) : 32'h0;
            end
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (bus.mem_ack) begin
            state_q  <= DONE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            cnt_q    <= '0;
            if (we_q) begin
              st_done_q <= 1'b1;
            end else begin
              wb_valid_q    <= 1'b1;
              load_signal_q <= size_q;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q       <= ERR;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.stall       = (state_q != IDLE);
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.load_signal = load_signal_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.st_done     = st_done_q;
  assign bus.align_err   = align_err_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed cases from the test plan plus random
// loads/stores, with expectations from a size/address-rule reference model.
module tb_mem_access_ctrl;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;
  } mem_exp_t;

  typedef struct {
    logic [3:0] kind;  // {timeout, align, st_done, wb_valid}
    logic [1:0] ls;
  } evt_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mem_exp_t exp_mem[$];
  evt_exp_t exp_evt[$];

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: lane rules written as arithmetic on the byte offset.
  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (sz == 2'b00) return 4'hF;
    if (sz == 2'b01) return (off >= 2) ? 4'hC : 4'h3;
    return 4'(1 << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic we, input logic [1:0] sz, input logic [31:0] w);
    if (!we) return 32'h0;
    if (sz == 2'b00) return w;
    if (sz == 2'b01) return 32'(w[15:0]) * 32'h0001_0001;
    return 32'(w[7:0]) * 32'h0101_0101;
  endfunction

  function automatic logic m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return (a % 4) != 0;
    if (sz == 2'b01) return (a % 2) != 0;
    return 1'b0;
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  mem_exp_t cur;
  int       en_len = 0;
  always @(negedge clk) begin
    logic [3:0] pulses;
    evt_exp_t   e;
    if (!rst_n) begin
      en_len = 0;
    end else begin
      if (bus.mem_en) begin
        if (en_len == 0) begin
          if (exp_mem.size() == 0) chk("mem_unexpected", 32'd1, 32'd0);
          else cur = exp_mem.pop_front();
        end
        en_len++;
        chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
        chk("mem_addr", bus.mem_addr, cur.addr);
        chk("mem_be", 32'(bus.mem_be), 32'(cur.be));
        chk("mem_wdata", bus.mem_wdata, cur.wdata);
      end else if (en_len != 0) begin
        chk("mem_en_len", 32'(en_len), 32'(cur.len));
        en_len = 0;
      end
      pulses = {bus.timeout_err, bus.align_err, bus.st_done, bus.wb_valid};
      if (pulses != 4'b0) begin
        if (exp_evt.size() == 0) begin
          chk("evt_unexpected", 32'(pulses), 32'd0);
        end else begin
          e = exp_evt.pop_front();
          chk("evt_kind", 32'(pulses), 32'(e.kind));
          if (e.kind == 4'b0001) chk("load_signal", 32'(bus.load_signal), 32'(e.ls));
          chk("stall_busy", 32'(bus.stall), 32'd1);
          chk("ready_busy", 32'(bus.req_ready), 32'd0);
        end
      end
    end
  end

  // Driver: issues one request and plays the memory, acking on mem_en cycle d+1
  // (d >= TIMEOUT means never).
  task automatic do_req(input logic we, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int d);
    int       n;
    int       guard;
    logic     mis;
    mem_exp_t m;
    evt_exp_t e;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      chk("ready_wait_expired", 32'd0, 32'd1);
      return;
    end
    if ($urandom_range(0, 3) == 0) begin
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    mis = m_misaligned(sz, a);
    if (mis) begin
      e.kind = 4'b0100;
      e.ls   = 2'b00;
      exp_evt.push_back(e);
    end else begin
      m.we    = we;
      m.addr  = a & 32'hFFFF_FFFC;
      m.wdata = m_wdata(we, sz, wd);
      m.be    = m_be(sz, a);
      m.len   = (d >= TIMEOUT) ? TIMEOUT : d + 1;
      exp_mem.push_back(m);
      e.ls   = sz;
      if (d >= TIMEOUT) e.kind = 4'b1000;
      else e.kind = we ? 4'b0010 : 4'b0001;
      exp_evt.push_back(e);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (!mis) begin
      n = 0;
      @(negedge clk);
      while (bus.mem_en && n < TIMEOUT + 4) begin
        n++;
        bus.mem_ack = (n == d + 1);
        // A request shown while busy must not be taken.
        if (d >= 2 && n == 1) begin
          bus.req_valid = 1'b1;
          bus.req_addr  = $urandom;
          bus.req_wdata = $urandom;
        end else begin
          bus.req_valid = 1'b0;
        end
        @(negedge clk);
      end
      bus.mem_ack   = 1'b0;
      bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    mem_exp_t m;
    int       guard;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;

    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_load_signal", 32'(bus.load_signal), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_stall", 32'(bus.stall), 32'd0);

    do_req(1'b0, 2'b00, 32'h0000_0010, 32'h0, 2);
    do_req(1'b1, 2'b01, 32'h0000_0022, 32'h0000_ABCD, 0);
    for (int i = 0; i < 4; i++) do_req(1'b0, 2'b10, 32'h40 + 32'(i), 32'h0, i);
    do_req(1'b0, 2'b11, 32'h0000_0041, 32'h0, 1);
    do_req(1'b0, 2'b00, 32'h0000_0006, 32'h0, 0);
    do_req(1'b1, 2'b01, 32'h0000_0003, 32'h1234_5678, 0);
    do_req(1'b0, 2'b00, 32'h0000_0100, 32'h0, 100);
    do_req(1'b0, 2'b00, 32'h0000_0104, 32'h0, TIMEOUT - 1);

    // Reset during the second REQ cycle aborts with no completion pulse.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h0000_0080;
    m.we = 1'b0; m.addr = 32'h80; m.wdata = 32'h0; m.be = 4'hF; m.len = 2;
    exp_mem.push_back(m);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_en", 32'(bus.mem_en), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    do_req(1'b1, 2'b00, 32'h0000_0084, 32'hDEAD_BEEF, 1);

    for (int i = 0; i < 60; i++)
      do_req(1'($urandom), 2'($urandom), $urandom, $urandom, int'($urandom_range(0, 20)));

    guard = 0;
    while ((exp_evt.size() != 0 || exp_mem.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("evt_queue_drained", 32'(exp_evt.size()), 32'd0);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    chk("final_ready", 32'(bus.req_ready), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
